// File: rtl/fpu_req_sequencer_if.sv
// Request/ALU/response bundle for the FPU request sequencer.
// slave is the sequencer's view; master is the requester/ALU/consumer side.
interface fpu_req_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_oper;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] input1;
   logic [31:0] input2;
   logic [1:0]  oper;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic        exception;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [2:0]  rsp_flags;
   logic [1:0]  rsp_oper;

   modport slave (
      input  req_valid, req_oper, req_a, req_b, result, overflow, underflow, exception,
             rsp_ready,
      output req_ready, input1, input2, oper, rsp_valid, rsp_result, rsp_flags, rsp_oper
   );

   modport master (
      output req_valid, req_oper, req_a, req_b, result, overflow, underflow, exception,
             rsp_ready,
      input  req_ready, input1, input2, oper, rsp_valid, rsp_result, rsp_flags, rsp_oper
   );
endinterface

// File: rtl/fpu_req_sequencer.sv
// Sequences one request at a time through a combinational FPU: holds operands for
// SETTLE_CYCLES edges, captures result and flags, then holds the response until taken.
module fpu_req_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fpu_req_sequencer_if.slave    bus,
   output logic [CNT_W-1:0]      exc_count
);

   typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       input1_q, input1_d;
   logic [31:0]       input2_q, input2_d;
   logic [1:0]        oper_q, oper_d;
   logic [1:0]        rsp_oper_q, rsp_oper_d;
   logic [31:0]       rsp_result_q, rsp_result_d;
   logic [2:0]        rsp_flags_q, rsp_flags_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [CNT_W-1:0]  exc_count_q, exc_count_d;
   logic [2:0]        alu_flags;

   assign alu_flags = {bus.exception, bus.overflow, bus.underflow};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      input1_d     = input1_q;
      input2_d     = input2_q;
      oper_d       = oper_q;
      rsp_oper_d   = rsp_oper_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_valid_d  = rsp_valid_q;
      exc_count_d  = exc_count_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               input1_d   = bus.req_a;
               input2_d   = bus.req_b;
               oper_d     = bus.req_oper;
               rsp_oper_d = bus.req_oper;
               cnt_d      = 4'(SETTLE_CYCLES - 1);
               state_d    = StSettle;
            end
         end
         StSettle: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_result_d = bus.result;
               rsp_flags_d  = alu_flags;
               rsp_valid_d  = 1'b1;
               // Saturate rather than wrap so a long error burst stays visible.
               if ((|alu_flags) && (exc_count_q != '1)) begin
                  exc_count_d = exc_count_q + CNT_W'(1);
               end
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         input1_q     <= 32'd0;
         input2_q     <= 32'd0;
         oper_q       <= 2'd0;
         rsp_oper_q   <= 2'd0;
         rsp_result_q <= 32'd0;
         rsp_flags_q  <= 3'd0;
         rsp_valid_q  <= 1'b0;
         exc_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         input1_q     <= input1_d;
         input2_q     <= input2_d;
         oper_q       <= oper_d;
         rsp_oper_q   <= rsp_oper_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_valid_q  <= rsp_valid_d;
         exc_count_q  <= exc_count_d;
      end
   end

   // Ready is held low while reset is asserted, not just after the first edge.
   assign bus.req_ready  = rst_n && (state_q == StIdle);
   assign bus.input1     = input1_q;
   assign bus.input2     = input2_q;
   assign bus.oper       = oper_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_oper   = rsp_oper_q;
   assign exc_count      = exc_count_q;

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Directed bench: instance a uses defaults (settle 2, 8-bit count); instance b uses
// settle 3 with a 2-bit count for saturation and capture-timing checks.
module tb_fpu_req_sequencer;
   logic clk = 1'b0;
   logic rst_na = 1'b0;
   logic rst_nb = 1'b0;
   logic [7:0] exc_a;
   logic [1:0] exc_b;
   int n_cmp = 0;
   int n_err = 0;

   fpu_req_sequencer_if ifa ();
   fpu_req_sequencer_if ifb ();

   fpu_req_sequencer #(.SETTLE_CYCLES(2), .CNT_W(8)) dut_a (
      .clk       (clk),
      .rst_n     (rst_na),
      .bus       (ifa),
      .exc_count (exc_a)
   );

   fpu_req_sequencer #(.SETTLE_CYCLES(3), .CNT_W(2)) dut_b (
      .clk       (clk),
      .rst_n     (rst_nb),
      .bus       (ifb),
      .exc_count (exc_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k, nrsp, last, nt;
      logic acc, seen;
      {ifa.req_valid, ifa.req_oper, ifa.req_a, ifa.req_b, ifa.result} = '0;
      {ifa.overflow, ifa.underflow, ifa.exception, ifa.rsp_ready} = '0;
      {ifb.req_valid, ifb.req_oper, ifb.req_a, ifb.req_b, ifb.result} = '0;
      {ifb.overflow, ifb.underflow, ifb.exception, ifb.rsp_ready} = '0;

      // Reset state
      #1;
      check("rst_ready_low", 32'(ifa.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
      check("rst_input1", ifa.input1, 32'd0);
      check("rst_exc", 32'(exc_a), 32'd0);
      tick();
      tick();
      #2;
      rst_na = 1'b1;
      rst_nb = 1'b1;
      tick();
      check("rst_ready_high", 32'(ifa.req_ready), 32'd1);
      check("rst_input2", ifa.input2, 32'd0);
      check("rst_oper", 32'(ifa.oper), 32'd0);
      check("rst_rsp_oper", 32'(ifa.rsp_oper), 32'd0);
      check("rst_rsp_result", ifa.rsp_result, 32'd0);
      check("rst_rsp_flags", 32'(ifa.rsp_flags), 32'd0);

      // Single add, latency 2
      ifa.req_a = 32'hC0B2511A;
      ifa.req_b = 32'h43116505;
      ifa.req_oper = 2'd0;
      ifa.result = 32'h430BD28F;
      ifa.req_valid = 1'b1;
      tick();
      ifa.req_valid = 1'b0;
      check("add_input1", ifa.input1, 32'hC0B2511A);
      check("add_input2", ifa.input2, 32'h43116505);
      check("add_ready_busy", 32'(ifa.req_ready), 32'd0);
      tick();
      check("add_lat_early", 32'(ifa.rsp_valid), 32'd0);
      tick();
      check("add_lat_valid", 32'(ifa.rsp_valid), 32'd1);
      check("add_result", ifa.rsp_result, 32'h430BD28F);
      check("add_flags", 32'(ifa.rsp_flags), 32'd0);
      check("add_rsp_oper", 32'(ifa.rsp_oper), 32'd0);
      check("add_exc", 32'(exc_a), 32'd0);

      // Backpressure: response held, second request ignored, ALU changes ignored
      ifa.req_a = 32'hDEADBEEF;
      ifa.req_oper = 2'd2;
      ifa.req_valid = 1'b1;
      ifa.result = 32'h0;
      ifa.exception = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid", 32'(ifa.rsp_valid), 32'd1);
         check("bp_result", ifa.rsp_result, 32'h430BD28F);
         check("bp_ready", 32'(ifa.req_ready), 32'd0);
         check("bp_input1", ifa.input1, 32'hC0B2511A);
      end
      ifa.req_valid = 1'b0;
      ifa.exception = 1'b0;
      ifa.rsp_ready = 1'b1;
      tick();
      ifa.rsp_ready = 1'b0;
      check("bp_release_valid", 32'(ifa.rsp_valid), 32'd0);
      check("bp_release_ready", 32'(ifa.req_ready), 32'd1);
      check("bp_no_accept", 32'(ifa.oper), 32'd0);
      check("bp_exc", 32'(exc_a), 32'd0);

      // Reset during SETTLE discards the transaction
      ifa.req_a = 32'd1;
      ifa.req_b = 32'd2;
      ifa.req_oper = 2'd1;
      ifa.req_valid = 1'b1;
      tick();
      ifa.req_valid = 1'b0;
      tick();
      #2;
      rst_na = 1'b0;
      #1;
      check("mrst_input1", ifa.input1, 32'd0);
      check("mrst_oper", 32'(ifa.oper), 32'd0);
      check("mrst_rsp_oper", 32'(ifa.rsp_oper), 32'd0);
      check("mrst_result", ifa.rsp_result, 32'd0);
      check("mrst_ready", 32'(ifa.req_ready), 32'd0);
      #1;
      rst_na = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mrst_no_rsp", 32'(ifa.rsp_valid), 32'd0);
      end
      ifa.req_a = 32'd5;
      ifa.req_b = 32'd6;
      ifa.req_oper = 2'd2;
      ifa.result = 32'h3F800000;
      ifa.overflow = 1'b1;
      ifa.req_valid = 1'b1;
      tick();
      ifa.req_valid = 1'b0;
      check("post_input1", ifa.input1, 32'd5);
      tick();
      check("post_lat_early", 32'(ifa.rsp_valid), 32'd0);
      tick();
      check("post_lat_valid", 32'(ifa.rsp_valid), 32'd1);
      check("post_result", ifa.rsp_result, 32'h3F800000);
      check("post_flags", 32'(ifa.rsp_flags), 32'b010);
      check("post_rsp_oper", 32'(ifa.rsp_oper), 32'd2);
      check("post_exc", 32'(exc_a), 32'd1);
      ifa.overflow = 1'b0;
      ifa.rsp_ready = 1'b1;
      tick();

      // Four back-to-back requests, consumer always ready
      k = 0;
      nrsp = 0;
      last = 0;
      ifa.req_oper = 2'd0;
      ifa.req_valid = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         acc = ifa.req_ready && ifa.req_valid;
         tick();
         if (acc) begin
            k++;
            if (k == 4) ifa.req_valid = 1'b0;
            else ifa.req_oper = 2'(k);
         end
         if (ifa.rsp_valid) begin
            check("b2b_oper", 32'(ifa.rsp_oper), 32'(nrsp));
            if (nrsp > 0) check("b2b_spacing", 32'(cyc - last), 32'd4);
            last = cyc;
            nrsp++;
         end
      end
      check("b2b_count", 32'(nrsp), 32'd4);
      check("b2b_exc", 32'(exc_a), 32'd1);

      // Saturation on a 2-bit counter, settle 3
      ifb.rsp_ready = 1'b1;
      ifb.exception = 1'b1;
      ifb.req_oper = 2'd3;
      for (int i = 0; i < 5; i++) begin
         ifb.req_valid = 1'b1;
         tick();
         ifb.req_valid = 1'b0;
         seen = 1'b0;
         nt = 0;
         for (int j = 0; j < 10; j++) begin
            tick();
            nt++;
            if (ifb.rsp_valid) begin
               seen = 1'b1;
               break;
            end
         end
         check("sat_seen", 32'(seen), 32'd1);
         check("sat_latency", 32'(nt), 32'd3);
         check("sat_flags", 32'(ifb.rsp_flags), 32'b100);
         check("sat_exc", 32'(exc_b), (i >= 2) ? 32'd3 : 32'(i + 1));
         tick();
      end

      // Capture takes the ALU value present at the capture edge only
      ifb.exception = 1'b0;
      ifb.rsp_ready = 1'b0;
      ifb.result = 32'h11111111;
      ifb.req_oper = 2'd0;
      ifb.req_valid = 1'b1;
      tick();
      ifb.req_valid = 1'b0;
      tick();
      tick();
      check("iso_early", 32'(ifb.rsp_valid), 32'd0);
      ifb.result = 32'h22222222;
      tick();
      check("iso_valid", 32'(ifb.rsp_valid), 32'd1);
      check("iso_result", ifb.rsp_result, 32'h22222222);
      check("iso_flags", 32'(ifb.rsp_flags), 32'd0);
      check("iso_exc", 32'(exc_b), 32'd3);
      ifb.result = 32'h33333333;
      tick();
      check("iso_hold", ifb.rsp_result, 32'h22222222);
      check("iso_hold_valid", 32'(ifb.rsp_valid), 32'd1);
      ifb.rsp_ready = 1'b1;
      tick();
      check("iso_done", 32'(ifb.rsp_valid), 32'd0);
      check("iso_ready", 32'(ifb.req_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fpu_req_sequencer.md
FPU_REQ_SEQUENCER -- requirements
Module: fpu_req_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, cycles the ALU operands are held before the result is captured (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8, width of the saturating exception counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_oper  input  2  0 add, 1 sub, 2 mul, 3 div.
REQ-008 req_a, req_b  input  32  IEEE-754 single-precision operands.
REQ-009 input1, input2  output  32  operands driven to the combinational ALU.
REQ-010 oper  output  2  operation code driven to the ALU.
REQ-011 result  input  32  ALU result.
REQ-012 overflow, underflow, exception  input  1 each  ALU status flags.
REQ-013 rsp_valid  output  1  response held for the consumer.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_result  output  32  captured ALU result.
REQ-016 rsp_flags  output  3  captured {exception, overflow, underflow}.
REQ-017 rsp_oper  output  2  opcode of the request that produced the response.
REQ-018 exc_count  output  CNT_W  saturating count of responses with any flag set.

Function
REQ-019 SHALL implement FSM states IDLE, SETTLE, RESP; IDLE is the only state with req_ready=1.
REQ-020 IDLE: req_valid&req_ready at an edge SHALL load input1<=req_a, input2<=req_b, oper<=req_oper, rsp_oper<=req_oper, cnt<=SETTLE_CYCLES-1, go to SETTLE.
REQ-021 SETTLE: while cnt!=0, cnt SHALL decrement each edge; at the edge with cnt==0, rsp_result<=result, rsp_flags<={exception,overflow,underflow}, rsp_valid<=1, go to RESP.
REQ-022 Latency SHALL be exactly SETTLE_CYCLES edges from the accept edge to the edge raising rsp_valid.
REQ-023 input1, input2 and oper SHALL stay constant from the accept edge until the next accept; ALU inputs are never changed while SETTLE is active.
REQ-024 RESP: rsp_valid, rsp_result, rsp_flags and rsp_oper SHALL hold stable until rsp_valid&rsp_ready at an edge, which clears rsp_valid and returns to IDLE.
REQ-025 Throughput SHALL be at most one request per SETTLE_CYCLES+2 cycles; req_ready rises the cycle after the response handshake.
REQ-026 req_valid outside IDLE SHALL be ignored; no request is queued or dropped silently after acceptance.
REQ-027 At the capture edge, if any captured flag is 1, exc_count SHALL increment by 1, saturating at all-ones.
REQ-028 ALU input changes during SETTLE outside the capture edge SHALL have no effect on outputs.
REQ-029 rsp_ready while not in RESP SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, cnt=0, req_ready=1 after release (0 while asserted), rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_oper=0, input1=0, input2=0, oper=0, exc_count=0.
REQ-031 Reset mid-SETTLE or mid-RESP SHALL discard the transaction with no response and no exc_count update.

Verification
REQ-032 Single add: SETTLE_CYCLES=2, req_a=C0B2511A, req_b=43116505, oper=0; stub ALU returns 430BD28F, flags 0 -> rsp_valid rises exactly 2 edges after accept, rsp_result=430BD28F, rsp_flags=000, rsp_oper=0, exc_count=0.
REQ-033 Backpressure: rsp_ready held 0 for 10 cycles after rsp_valid -> outputs stable, req_ready=0, a second req_valid ignored; rsp_ready=1 -> IDLE, req_ready=1 next cycle.
REQ-034 Flags/saturation: CNT_W=2, stub exception=1 on five consecutive divs -> rsp_flags=100 each, exc_count 1,2,3,3,3.
REQ-035 Settle isolation: stub changes result from 11111111 to 22222222 one cycle before capture with SETTLE_CYCLES=3 -> rsp_result=22222222; a change on the cycle after capture leaves 22222222.
REQ-036 Reset mid-operation: rst_n pulsed low during SETTLE -> rsp_valid never asserts, all outputs zero, next request completes normally with latency SETTLE_CYCLES.
REQ-037 Four requests add/sub/mul/div back-to-back with rsp_ready=1 -> four responses, rsp_oper 0,1,2,3 in order, spacing SETTLE_CYCLES+2 cycles.
